// File: rtl/ghostbus_regbank_pkg.sv
// Shared helpers for the ghostbus register bank: width math, address-window
// decode and the read-latency ceiling.
package ghostbus_regbank_pkg;

  localparam int RLAT_MAX = 4;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Half-open window [base, base+n); operands widened so base+n cannot wrap.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] n);
    return (addr >= base) && (addr < base + n);
  endfunction

endpackage

// File: rtl/ghostbus_rdpipe.sv
// Fixed-depth valid/data shift pipeline carrying read responses to the bus.
// Async clear drops anything in flight.
module ghostbus_rdpipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH:1] vld_pipe;
  logic [W-1:0]   dat_pipe [DEPTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= DEPTH; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= vld_i;
      dat_pipe[1] <= data_i;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign vld_o  = vld_pipe[DEPTH];
  assign data_o = dat_pipe[DEPTH];

endmodule

// File: rtl/ghostbus_regbank.sv
// NCH host-accessible channel registers with write/read strobes plus a
// host-writable RAM read by the application, behind a local ghostbus slave.
module ghostbus_regbank
  import ghostbus_regbank_pkg::*;
#(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 32,
  parameter int unsigned GW       = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned REG_BASE = 'h00,
  parameter int unsigned RAM_BASE = 'h40,
  parameter int unsigned RD       = 8,
  parameter int unsigned RW       = 4,
  parameter int          RLAT     = 1,
  parameter logic [GW-1:0]  INIT    = 'h42,
  parameter logic [NCH-1:0] RO_MASK = '0,
  localparam int RAW = clog2(RD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       bus_addr,
  input  logic [DW-1:0]       bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [DW-1:0]       bus_rdata,
  output logic                bus_rvalid,
  output logic [NCH*GW-1:0]   reg_q,
  output logic [NCH-1:0]      reg_ws,
  output logic [NCH-1:0]      reg_rs,
  input  logic [NCH*GW-1:0]   sts_in,
  input  logic [RAW-1:0]      app_raddr,
  output logic [RW-1:0]       app_rdata
);

  if (RLAT < 1 || RLAT > RLAT_MAX) begin : g_bad_rlat
    $error("ghostbus_regbank: RLAT out of range");
  end
  if (GW > DW || RW > DW) begin : g_bad_width
    $error("ghostbus_regbank: GW and RW must not exceed DW");
  end
  if (!((REG_BASE + NCH <= RAM_BASE) || (RAM_BASE + RD <= REG_BASE))) begin : g_bad_map
    $error("ghostbus_regbank: register and RAM windows overlap");
  end
  if (RD < 2 || (RD & (RD - 1)) != 0 || (RAM_BASE % RD) != 0) begin : g_bad_ram
    $error("ghostbus_regbank: RD must be a power of 2 >= 2 and RAM_BASE RD-aligned");
  end
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("ghostbus_regbank: NCH out of range");
  end

  logic [AW-1:0]  reg_off, ram_off;
  logic           reg_hit, ram_hit;
  logic [RAW-1:0] ram_idx;
  logic [NCH-1:0] ch_sel;

  assign reg_hit = in_range(64'(bus_addr), 64'(REG_BASE), 64'(NCH));
  assign ram_hit = in_range(64'(bus_addr), 64'(RAM_BASE), 64'(RD));
  assign reg_off = bus_addr - AW'(REG_BASE);
  assign ram_off = bus_addr - AW'(RAM_BASE);
  assign ram_idx = ram_off[RAW-1:0];

  logic [NCH-1:0][GW-1:0] chan_q;
  logic [NCH-1:0][GW-1:0] rd_view;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_sel[k] = reg_hit && (reg_off == AW'(k));
    if (RO_MASK[k]) begin : g_ro
      // Host writes are dropped; the bus sees the live status input.
      assign chan_q[k]  = INIT;
      assign rd_view[k] = sts_in[k*GW +: GW];
    end else begin : g_rw
      logic [GW-1:0] val_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   val_q <= INIT;
        else if (bus_we && ch_sel[k]) val_q <= bus_wdata[GW-1:0];
      end
      assign chan_q[k]  = val_q;
      assign rd_view[k] = val_q;
    end
  end

  assign reg_q = chan_q;

  logic [NCH-1:0] reg_ws_d, reg_ws_q, reg_rs_d, reg_rs_q;

  always_comb begin
    reg_ws_d = bus_we ? ch_sel : '0;
    reg_rs_d = bus_re ? ch_sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_ws_q <= '0;
      reg_rs_q <= '0;
    end else begin
      reg_ws_q <= reg_ws_d;
      reg_rs_q <= reg_rs_d;
    end
  end

  assign reg_ws = reg_ws_q;
  assign reg_rs = reg_rs_q;

  logic [RW-1:0] mem [RD];
  logic [RW-1:0] app_rdata_q;

  always_ff @(posedge clk) begin
    if (bus_we && ram_hit) mem[ram_idx] <= bus_wdata[RW-1:0];
  end

  // Reads the array at the same edge as any host write, so the app sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) app_rdata_q <= '0;
    else        app_rdata_q <= mem[app_raddr];
  end

  assign app_rdata = app_rdata_q;

  // Read data is captured combinationally before this edge's writes land.
  logic [DW-1:0] rd_d;

  always_comb begin
    rd_d = '0;
    if (bus_re) begin
      for (int k = 0; k < NCH; k++)
        if (ch_sel[k]) rd_d = DW'(rd_view[k]);
      if (ram_hit) rd_d = DW'(mem[ram_idx]);
    end
  end

  ghostbus_rdpipe #(
    .DEPTH (RLAT),
    .W     (DW)
  ) u_rdpipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (bus_re),
    .data_i (rd_d),
    .vld_o  (bus_rvalid),
    .data_o (bus_rdata)
  );

endmodule

// File: tb/tb_ghostbus_regbank.sv
// Bench for ghostbus_regbank (RLAT=3, channel 0 read-only): read responses are
// scoreboarded at issue and checked for data and exact latency on rvalid.
module tb_ghostbus_regbank;

  localparam int AW = 24, DW = 32, GW = 8, NCH = 4, RD = 8, RW = 4, RAW = 3;
  localparam int RLAT = 3;
  localparam int REG_BASE = 'h00, RAM_BASE = 'h40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     bus_addr = '0;
  logic [DW-1:0]     bus_wdata = '0;
  logic              bus_we = 1'b0, bus_re = 1'b0;
  logic [DW-1:0]     bus_rdata;
  logic              bus_rvalid;
  logic [NCH*GW-1:0] reg_q;
  logic [NCH-1:0]    reg_ws, reg_rs;
  logic [NCH*GW-1:0] sts_in = 32'h0000_0042;
  logic [RAW-1:0]    app_raddr = '0;
  logic [RW-1:0]     app_rdata;

  ghostbus_regbank #(
    .AW(AW), .DW(DW), .GW(GW), .NCH(NCH), .REG_BASE(REG_BASE), .RAM_BASE(RAM_BASE),
    .RD(RD), .RW(RW), .RLAT(RLAT), .INIT(8'h42), .RO_MASK(4'b0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .reg_q(reg_q), .reg_ws(reg_ws), .reg_rs(reg_rs), .sts_in(sts_in),
    .app_raddr(app_raddr), .app_rdata(app_rdata)
  );

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got rdata=%h at cycle %0d, required no rvalid", bus_rdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus_rdata !== e.data || cyc != e.cyc + RLAT) begin
          errors++;
          $display("FAIL read_resp: got %h at cycle %0d, required %h at cycle %0d",
                   bus_rdata, cyc, e.data, e.cyc + RLAT);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_t x;
    drive(1'b0, 1'b1, a, '0);
    x.data = e; x.cyc = cyc;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (reg_ws !== '0 || reg_rs !== '0 || bus_rvalid !== 1'b0 || bus_rdata !== '0 || app_rdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ws=%b rs=%b rvalid=%b rdata=%h app=%h, required all 0",
                 reg_ws, reg_rs, bus_rvalid, bus_rdata, app_rdata);
      end
    end
    checks++;
    if (reg_q !== 32'h4242_4242) begin
      errors++;
      $display("FAIL reset_reg_q: got %h, required 42424242", reg_q);
    end
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) rd(AW'(REG_BASE + k), 32'h42);
    idle();
    drain();
  endtask

  task automatic test_write_reg();
    wr(AW'(REG_BASE + 2), 32'h1234_56A5);
    idle();
    checks++;
    if (reg_q[23:16] !== 8'hA5 || reg_ws !== 4'b0100) begin
      errors++;
      $display("FAIL write_ch2: reg_q=%h ws=%b, required byte2=a5 ws=0100", reg_q, reg_ws);
    end
    idle();
    checks++;
    if (reg_ws !== 4'b0000) begin
      errors++;
      $display("FAIL ws_one_cycle: got %b, required 0000", reg_ws);
    end
    rd(AW'(REG_BASE + 2), 32'h0000_00A5);
    idle();
    checks++;
    if (reg_rs !== 4'b0100) begin
      errors++;
      $display("FAIL rs_ch2: got %b, required 0100", reg_rs);
    end
    drain();
  endtask

  task automatic test_ro();
    sts_in[7:0] = 8'h3C;
    wr(AW'(REG_BASE), 32'hFF);
    idle();
    checks++;
    if (reg_ws !== 4'b0001 || reg_q[7:0] !== 8'h42) begin
      errors++;
      $display("FAIL ro_write: ws=%b reg_q0=%h, required ws=0001 reg_q0=42", reg_ws, reg_q[7:0]);
    end
    rd(AW'(REG_BASE), 32'h3C);
    idle();
    drain();
  endtask

  task automatic test_ram();
    for (int i = 0; i < RD; i++) wr(AW'(RAM_BASE + i), DW'(i) | 32'hABC0);
    idle();
    for (int i = 0; i < RD; i++) begin
      @(negedge clk); app_raddr = RAW'(i);
      @(negedge clk);
      checks++;
      if (app_rdata !== RW'(i)) begin
        errors++;
        $display("FAIL app_read[%0d]: got %h, required %h", i, app_rdata, RW'(i));
      end
    end
    rd(AW'(RAM_BASE + 5), 32'h5);
    idle();
    drain();
    @(negedge clk); app_raddr = 3'd3;
    bus_we = 1'b1; bus_addr = AW'(RAM_BASE + 3); bus_wdata = 32'hA;
    idle();
    checks++;
    if (app_rdata !== 4'h3) begin
      errors++;
      $display("FAIL app_read_first: got %h, required 3", app_rdata);
    end
    @(negedge clk);
    checks++;
    if (app_rdata !== 4'hA) begin
      errors++;
      $display("FAIL app_new_data: got %h, required a", app_rdata);
    end
  endtask

  task automatic test_unmapped();
    wr(AW'(REG_BASE + NCH), 32'hFF);
    idle();
    checks++;
    if (reg_ws !== 4'b0000 || reg_q !== 32'h42A5_4242) begin
      errors++;
      $display("FAIL unmapped_write: ws=%b reg_q=%h, required 0000 / 42a54242", reg_ws, reg_q);
    end
    wr(AW'(RAM_BASE + RD), 32'h9);
    rd(AW'(REG_BASE + NCH), 32'h0);
    rd(AW'(RAM_BASE + RD), 32'h0);
    rd(AW'(RAM_BASE - 1), 32'h0);
    rd(AW'(RAM_BASE + RD - 1), 32'h7);
    idle();
    checks++;
    if (reg_rs !== 4'b0000) begin
      errors++;
      $display("FAIL unmapped_rs: got %b, required 0000", reg_rs);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    rd(AW'(REG_BASE + 1), 32'h42);
    rd(AW'(RAM_BASE + 2), 32'h2);
    rd(24'h80, 32'h0);
    rd(AW'(REG_BASE + 2), 32'hA5);
    idle();
    drain();
  endtask

  task automatic test_rw_same();
    exp_t x;
    drive(1'b1, 1'b1, AW'(REG_BASE + 1), 32'h11);
    x.data = 32'h42; x.cyc = cyc;
    sb.push_back(x);
    idle();
    checks++;
    if (reg_ws !== 4'b0010 || reg_rs !== 4'b0010 || reg_q[15:8] !== 8'h11) begin
      errors++;
      $display("FAIL rw_same: ws=%b rs=%b reg_q1=%h, required 0010/0010/11", reg_ws, reg_rs, reg_q[15:8]);
    end
    drain();
  endtask

  task automatic test_reset_midread();
    int cnt;
    drive(1'b0, 1'b1, AW'(REG_BASE + 1), '0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_rvalid) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL reset_midread: %0d rvalid pulses, required 0", cnt);
    end
    checks++;
    if (reg_q[15:8] !== 8'h42) begin
      errors++;
      $display("FAIL reset_reinit: reg_q1=%h, required 42", reg_q[15:8]);
    end
  endtask

  initial begin
    test_reset();
    test_write_reg();
    test_ro();
    test_ram();
    test_unmapped();
    test_back_to_back();
    test_rw_same();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
